// File: rtl/reg_load_arbiter.sv
// rtl/reg_load_arbiter.sv - round-robin arbiter that stages data and pulses pl into one shared regn
// The outputs are registered. pl, dout, gnt and ack change only on clock edges.
module reg_load_arbiter #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] din,
  output logic           pl,
  output logic [N-1:0]   dout,
  output logic [3:0]     gnt,
  output logic [3:0]     ack,
  output logic           busy,
  output logic [7:0]     load_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [1:0]   ptr, ptr_n;
  logic [1:0]   owner, owner_n;
  logic         pl_n;
  logic [N-1:0] dout_n;
  logic [3:0]   gnt_n;
  logic [3:0]   ack_n;
  logic [7:0]   load_cnt_n;

  logic         found;
  logic [1:0]   win;
  logic [1:0]   cand;

  // The first pending requester, searching upward from ptr modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    pl_n       = pl;
    dout_n     = dout;
    gnt_n      = gnt;
    ack_n      = ack;
    load_cnt_n = load_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          dout_n  = din[int'(win)*N +: N];
          gnt_n   = 4'b0001 << win;
          owner_n = win;
          pl_n    = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        pl_n    = 1'b0;
        ack_n   = 4'b0001 << owner;
        state_n = ACK;
      end
      ACK: begin
        ack_n      = 4'b0000;
        gnt_n      = 4'b0000;
        ptr_n      = owner + 2'd1;
        load_cnt_n = load_cnt + 8'd1;
        state_n    = IDLE;
      end
      default: begin
        pl_n    = 1'b0;
        gnt_n   = 4'b0000;
        ack_n   = 4'b0000;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      pl       <= 1'b0;
      dout     <= '0;
      gnt      <= 4'b0000;
      ack      <= 4'b0000;
      busy     <= 1'b0;
      load_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      pl       <= pl_n;
      dout     <= dout_n;
      gnt      <= gnt_n;
      ack      <= ack_n;
      busy     <= (state_n != IDLE);
      load_cnt <= load_cnt_n;
    end
  end

endmodule
